// File: rtl/matrix_entry_ctrl_if.sv
// Bundles the command strobes and write/status outputs of matrix_entry_ctrl.
// Ports: start/isdig/digitCode/enter/clear (plus bksp with ENTRY_BACKSPACE_EN) in;
//        wr_en/wr_row/wr_col/wr_data, cur_val, busy, done, ovf out of the controller.
// Modports: master = keypad front end / bench, slave = the entry controller.
interface matrix_entry_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic         isdig;
  logic [3:0]   digitCode;
  logic         enter;
  logic         clear;
`ifdef ENTRY_BACKSPACE_EN
  logic         bksp;
`endif
  logic         wr_en;
  logic [1:0]   wr_row;
  logic [1:0]   wr_col;
  logic [W-1:0] wr_data;
  logic [W-1:0] cur_val;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start, isdig, digitCode, enter, clear,
`ifdef ENTRY_BACKSPACE_EN
    output bksp,
`endif
    input  wr_en, wr_row, wr_col, wr_data, cur_val, busy, done, ovf
  );

  modport slave (
    input  start, isdig, digitCode, enter, clear,
`ifdef ENTRY_BACKSPACE_EN
    input  bksp,
`endif
    output wr_en, wr_row, wr_col, wr_data, cur_val, busy, done, ovf
  );
endinterface

// File: rtl/matrix_entry_ctrl.sv
// Purpose: turns keypad digit strobes into decimal element values, one row-major write per element.
// Latency: wr_en asserts the cycle after enter is sampled; ovf pulses the cycle after a rejected digit.
// Backpressure: none - matrix storage must accept every wr_en pulse.
// Ports: clk, nrst (sync, active-low), bus (matrix_entry_ctrl_if.slave).
// Optional: define ENTRY_BACKSPACE_EN to add the bksp strobe (acc/10, count-1).
module matrix_entry_ctrl #(
  parameter int DIM    = 2,
  parameter int MAXDIG = 3,
  parameter int W      = 8
) (
  input  logic               clk,
  input  logic               nrst,
  matrix_entry_ctrl_if.slave bus
);

  localparam int         CW   = $clog2(MAXDIG + 1);
  localparam logic [1:0] LAST = 2'(DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    row_q, col_q;
  logic          ovf_q;

  logic          bksp_s;
  logic [W+3:0]  acc_ext;
  logic          dig_ok;
  logic          last_elem;

`ifdef ENTRY_BACKSPACE_EN
  assign bksp_s = bus.bksp;
`else
  assign bksp_s = 1'b0;
`endif

  // acc*10 + digit in W+4 bits cannot wrap, so the range compare is exact.
  assign acc_ext   = (W+4)'(acc_q) * (W+4)'(10) + (W+4)'(bus.digitCode);
  assign dig_ok    = (cnt_q < CW'(MAXDIG)) && (bus.digitCode <= 4'd9) &&
                     (acc_ext <= (W+4)'({W{1'b1}}));
  assign last_elem = (row_q == LAST) && (col_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear wins from every state.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.start) state_d = ST_ENTRY;
        ST_ENTRY: if (bus.enter) state_d = ST_WRITE;
        ST_WRITE: state_d = last_elem ? ST_DONE : ST_ENTRY;
        ST_DONE:  if (bus.start) state_d = ST_ENTRY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: accumulator, digit count, element indices, reject pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (bus.clear) begin
        acc_q <= '0;
        cnt_q <= '0;
        row_q <= '0;
        col_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              acc_q <= '0;
              cnt_q <= '0;
              row_q <= '0;
              col_q <= '0;
            end
          end
          ST_ENTRY: begin
            if (bus.enter) begin
              // value is held for the WRITE cycle
            end else if (bksp_s) begin
              if (cnt_q != '0) begin
                acc_q <= acc_q / W'(10);
                cnt_q <= cnt_q - CW'(1);
              end
            end else if (bus.isdig) begin
              if (dig_ok) begin
                acc_q <= acc_ext[W-1:0];
                cnt_q <= cnt_q + CW'(1);
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            acc_q <= '0;
            cnt_q <= '0;
            if (col_q < LAST) begin
              col_q <= col_q + 2'd1;
            end else begin
              col_q <= '0;
              row_q <= row_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs; the write bus is forced to zero outside the WRITE cycle.
  always_comb begin
    bus.wr_en   = (state_q == ST_WRITE);
    bus.wr_row  = bus.wr_en ? row_q : 2'd0;
    bus.wr_col  = bus.wr_en ? col_q : 2'd0;
    bus.wr_data = bus.wr_en ? acc_q : '0;
    bus.cur_val = acc_q;
    bus.busy    = (state_q == ST_ENTRY) || (state_q == ST_WRITE);
    bus.done    = (state_q == ST_DONE);
    bus.ovf     = ovf_q;
  end

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Bench for matrix_entry_ctrl (DIM=2, MAXDIG=3, W=8): write scoreboard plus status checks.
module tb_matrix_entry_ctrl;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    int r;
    int c;
    int d;
  } wr_t;
  wr_t exp_q[$];

  matrix_entry_ctrl_if #(.W(8)) bus ();

  matrix_entry_ctrl #(.DIM(2), .MAXDIG(3), .W(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_row", int'(bus.wr_row), e.r);
        check("wr_col", int'(bus.wr_col), e.c);
        check("wr_data", int'(bus.wr_data), e.d);
      end
    end else if (nrst) begin
      check("idle_wr_bus", int'({bus.wr_row, bus.wr_col, bus.wr_data}), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input int d);
    bus.isdig = 1'b1;
    bus.digitCode = 4'(d);
    cyc();
    bus.isdig = 1'b0;
    bus.digitCode = 4'd0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  // enter, expect the write, then step out of WRITE
  task automatic commit(input int r, input int c, input int d);
    exp_q.push_back('{r, c, d});
    bus.enter = 1'b1;
    cyc();
    bus.enter = 1'b0;
    check("wr_en_after_enter", int'(bus.wr_en), 1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.isdig = 1'b0;
    bus.digitCode = 4'd0;
    bus.enter = 1'b0;
    bus.clear = 1'b0;
`ifdef ENTRY_BACKSPACE_EN
    bus.bksp = 1'b0;
`endif
    cyc();
    cyc();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_cur_val", int'(bus.cur_val), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    nrst = 1'b1;

    // single element 12
    pulse_start();
    check("busy_entry", int'(bus.busy), 1);
    digit(1);
    digit(2);
    check("cur_val_12", int'(bus.cur_val), 12);
    commit(0, 0, 12);
    check("cur_val_cleared", int'(bus.cur_val), 0);

    // full matrix 5,6,7,8
    pulse_clear();
    check("busy_after_clear", int'(bus.busy), 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      digit(5 + i);
      commit(i / 2, i % 2, 5 + i);
    end
    check("done_full", int'(bus.done), 1);
    check("busy_full", int'(bus.busy), 0);

    // overflow by value and by digit count, and an out-of-range code
    pulse_start();
    check("done_after_start", int'(bus.done), 0);
    digit(2);
    digit(5);
    digit(6);
    check("ovf_value", int'(bus.ovf), 1);
    check("cur_val_25", int'(bus.cur_val), 25);
    cyc();
    check("ovf_one_cycle", int'(bus.ovf), 0);
    commit(0, 0, 25);
    digit(1);
    digit(2);
    digit(3);
    check("ovf_none_3dig", int'(bus.ovf), 0);
    digit(4);
    check("ovf_count", int'(bus.ovf), 1);
    check("cur_val_123", int'(bus.cur_val), 123);
    commit(0, 1, 123);
    digit(12);
    check("ovf_bad_code", int'(bus.ovf), 1);
    check("cur_val_bad_code", int'(bus.cur_val), 0);

    // enter beats isdig; clear beats enter
    digit(4);
    bus.isdig = 1'b1;
    bus.digitCode = 4'd9;
    commit(1, 0, 4);
    bus.isdig = 1'b0;
    bus.digitCode = 4'd0;
    check("digit_dropped", int'(bus.cur_val), 0);
    digit(1);
    bus.enter = 1'b1;
    pulse_clear();
    bus.enter = 1'b0;
    check("clr_enter_busy", int'(bus.busy), 0);
    check("clr_enter_wr_en", int'(bus.wr_en), 0);
    cyc();

    // clear during WRITE: the write still happens
    pulse_start();
    digit(3);
    exp_q.push_back('{0, 0, 3});
    bus.enter = 1'b1;
    cyc();
    bus.enter = 1'b0;
    pulse_clear();
    check("clr_in_write_busy", int'(bus.busy), 0);

    // reset mid-entry, then restart at (0,0); start in ENTRY is ignored
    pulse_start();
    digit(3);
    digit(3);
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_cur_val", int'(bus.cur_val), 0);
    pulse_start();
    digit(9);
    commit(0, 0, 9);
    digit(7);
    pulse_start();
    check("start_ignored", int'(bus.cur_val), 7);
    commit(0, 1, 7);

`ifdef ENTRY_BACKSPACE_EN
    digit(4);
    digit(7);
    bus.bksp = 1'b1;
    cyc();
    bus.bksp = 1'b0;
    check("bksp_cur_val", int'(bus.cur_val), 4);
    digit(2);
    commit(1, 0, 42);
    bus.bksp = 1'b1;
    cyc();
    bus.bksp = 1'b0;
    check("bksp_empty_val", int'(bus.cur_val), 0);
    check("bksp_empty_ovf", int'(bus.ovf), 0);
`endif

    pulse_clear();
    cyc();
    check("all_writes_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_entry_ctrl.md
Name: matrix_entry_ctrl

Overview:
Sequences keypad digit entry into matrix elements for the matrix calculator. Consumes the per-digit strobe and decoded digit from the digit decoder stage. Accumulates multi-digit decimal values and issues one write per element into the matrix register file in row-major order. Sits between the keypad/digit-decode front end and the matrix storage.

Parameters:
DIM, 2, matrix dimension (DIM x DIM elements); legal 1..4
MAXDIG, 3, maximum decimal digits accepted per element
W, 8, element width in bits (unsigned)

Ports:
clk  in  1  system clock, all logic on rising edge
nrst  in  1  reset; synchronous and active-low
start  in  1  1-cycle strobe: begin entry of a new matrix
isdig  in  1  1-cycle strobe: a valid digit is on digitCode
digitCode  in  4  decoded digit 0..9
enter  in  1  1-cycle strobe: commit current value to current element
clear  in  1  1-cycle strobe: abort entry and return to IDLE
wr_en  out  1  1-cycle write strobe to matrix storage
wr_row  out  2  row index of write
wr_col  out  2  column index of write
wr_data  out  W  element value written
cur_val  out  W  running accumulator, for display
busy  out  1  high in ENTRY and WRITE
done  out  1  high in DONE
ovf  out  1  1-cycle pulse when a digit is rejected

Behaviour:
- Reset: sampled on rising clk while nrst=0. State=IDLE; acc, digit count, row, col = 0; all outputs 0. Reset mid-entry discards everything; no write is issued.
- States: IDLE, ENTRY, WRITE, DONE. The state register is updated on the clock edge.
- IDLE: start -> ENTRY with row=col=0, acc=0, count=0. All other inputs are ignored.
- ENTRY, per-cycle input priority is clear > enter > isdig. Lower-priority strobes in the same cycle are dropped.
- ENTRY, isdig: if count<MAXDIG and acc*10+digitCode <= 2^W-1, then acc <= acc*10+digitCode and count++. Otherwise acc is unchanged and ovf pulses for 1 cycle.
- Digit arithmetic: compute in W+4 bits before the compare.
- digitCode > 9 while isdig is high: treat as rejected and pulse ovf.
- ENTRY, enter -> WRITE. This is legal with count=0 and writes 0.
- WRITE, lasts exactly 1 cycle: wr_en=1, wr_row=row, wr_col=col, wr_data=acc. wr_en therefore asserts the cycle after enter is sampled.
- On leaving WRITE: acc and count are cleared.
  - If col<DIM-1: col++.
  - Else col=0 and row++.
  - If the element just written was (DIM-1, DIM-1): go to DONE. Otherwise go to ENTRY.
- Inputs in WRITE: isdig, enter and start are ignored. clear is honoured, but the write in that cycle still occurs.
- DONE: done=1 and held. start -> ENTRY (fresh matrix, indices 0). clear -> IDLE.
- clear from any state -> IDLE next cycle; acc, count, row and col are zeroed.
- start while in ENTRY or WRITE: ignored.
- wr_row, wr_col and wr_data are 0 whenever wr_en=0.
- cur_val = acc at all times.
- busy = (ENTRY | WRITE). done = (state==DONE).

Optional Feature:
Macro ENTRY_BACKSPACE_EN.
- Defined: extra input port bksp (1 bit, 1-cycle strobe).
  - In ENTRY with count>0: acc <= acc/10 and count--.
  - With count=0: no effect and no ovf.
  - Priority is clear > enter > bksp > isdig.
- Undefined: the bksp port and its logic are absent; behaviour otherwise identical.

Test Plan:
1. DIM=2, W=8, MAXDIG=3: reset, start, digits 1,2, enter -> next cycle wr_en=1, row=0, col=0, wr_data=12; cur_val returns to 0.
2. Full matrix: entries 5,6,7,8 each followed by enter -> writes (0,0)=5, (0,1)=6, (1,0)=7, (1,1)=8. done=1 the cycle after the 4th write; busy=0.
3. Overflow: digits 2,5,6 -> acc=25 and ovf pulses on the '6'. Then on a fresh element, digits 1,2,3,4 -> '4' rejected with an ovf pulse, and enter writes 123.
4. Priority: enter and isdig(digit 9) in the same cycle with acc=4 -> write 4, and the 9 is dropped. clear and enter in the same cycle -> IDLE, no wr_en.
5. Abort: nrst=0 for 1 cycle after digits 3,3 -> state IDLE, cur_val=0, no wr_en. A subsequent start begins at (0,0).
6. With ENTRY_BACKSPACE_EN: digits 4,7, bksp, 2, enter -> wr_data=42. bksp with count=0 -> no change and ovf stays 0.
